// File: rtl/regression_result_tx.sv
// regression_result_tx: serialises captured regression results as a nibble frame over a valid/ready link.
module regression_result_tx #(
  parameter int ELEM_WIDTH = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [2*ELEM_WIDTH-1:0]   c_packed,
  input  logic [ELEM_WIDTH-1:0]     det,
  input  logic                      invalid,
  output logic [3:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      tx_last,
  output logic                      busy,
  output logic                      sat
);
  localparam int W = ELEM_WIDTH;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [3:0] idx_q, idx_d, tx_data_q, tx_data_d;
  logic [W-1:0] det_q, det_d, b_q, b_d, m_q, m_d;
  logic inv_q, inv_d, sat_q, sat_d, last_q, last_d;
  logic [9:0] e_det, e_b, e_m;
  logic [39:0] frame;
  // Returns {saturated, negative, tens, ones}; magnitude is taken one bit wider so the most negative code is handled.
  function automatic logic [9:0] enc(input logic [W-1:0] v);
    logic [W:0] mag;
    logic [6:0] c;
    mag = v[W-1] ? -{v[W-1], v} : {v[W-1], v};
    c = (mag > 99) ? 7'd99 : mag[6:0];
    return {mag > 99, v[W-1], 4'(c / 7'd10), 4'(c % 7'd10)};
  endfunction
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    det_d = det_q;
    b_d = b_q;
    m_d = m_q;
    inv_d = inv_q;
    if (state_q == IDLE && load) begin
      state_d = SEND;
      idx_d = 4'd0;
      det_d = det;
      b_d = c_packed[W-1:0];
      m_d = c_packed[2*W-1:W];
      inv_d = invalid;
    end else if (state_q == SEND && tx_ready) begin
      state_d = last_q ? IDLE : SEND;
      idx_d = last_q ? 4'd0 : idx_q + 4'd1;
    end
    e_det = enc(det_d);
    e_b = enc(b_d);
    e_m = enc(m_d);
    sat_d = (state_q == IDLE && load) ? (e_det[9] | e_b[9] | e_m[9]) : sat_q;
    frame = {4'hA, {4{e_det[8]}}, e_det[7:0], {4{e_b[8]}}, e_b[7:0], {4{e_m[8]}}, e_m[7:0]};
    tx_data_d = (state_d == IDLE) ? 4'h0 : inv_d ? 4'hE : frame[39 - 4*idx_d -: 4];
    last_d = (state_d == SEND) && (inv_d || idx_d == 4'd9);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      det_q <= '0;
      b_q <= '0;
      m_q <= '0;
      inv_q <= 1'b0;
      sat_q <= 1'b0;
      last_q <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      det_q <= det_d;
      b_q <= b_d;
      m_q <= m_d;
      inv_q <= inv_d;
      sat_q <= sat_d;
      last_q <= last_d;
      tx_data_q <= tx_data_d;
    end
  end
  assign tx_valid = (state_q == SEND);
  assign busy = (state_q == SEND);
  assign tx_data = tx_data_q;
  assign tx_last = last_q;
  assign sat = sat_q;
endmodule

// File: tb/tb_regression_result_tx.sv
// tb_regression_result_tx: table vectors, corner sequences and random frames checked against a decimal-encoding model.
module tb_regression_result_tx;
  logic clk = 0, rst = 1, load = 0, invalid = 0, tx_ready = 0;
  logic [27:0] c_packed = '0;
  logic [13:0] det = '0;
  logic [3:0] tx_data;
  logic tx_valid, tx_last, busy, sat;
  int total = 0, bad = 0;
  regression_result_tx #(.ELEM_WIDTH(14)) dut (
    .clk(clk), .rst(rst), .load(load), .c_packed(c_packed), .det(det), .invalid(invalid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .busy(busy), .sat(sat)
  );
  always #5 clk = ~clk;
  typedef struct {
    int d, b, s;
    bit inv;
    logic [39:0] nibs;
    int len;
    bit sat;
    int mode;
  } vec_t;
  vec_t vt[8];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  // Reference: decimal digits of |v| clipped to 99, sign as 0x0/0xF.
  task automatic model(input int d, b, s, input bit inv, output logic [39:0] nibs, output int len, output bit st);
    int v[3];
    int a;
    v = '{d, b, s};
    nibs = '0;
    st = 0;
    for (int i = 0; i < 3; i++) if (v[i] > 99 || v[i] < -99) st = 1;
    if (inv) begin
      nibs[39:36] = 4'hE;
      len = 1;
    end else begin
      nibs[39:36] = 4'hA;
      for (int i = 0; i < 3; i++) begin
        a = (v[i] < 0) ? -v[i] : v[i];
        if (a > 99) a = 99;
        nibs[35 - 12*i -: 4] = (v[i] < 0) ? 4'hF : 4'h0;
        nibs[31 - 12*i -: 4] = 4'(a / 10);
        nibs[27 - 12*i -: 4] = 4'(a % 10);
      end
      len = 10;
    end
  endtask
  // Called at a negedge; mode 0 ready=1, 1 toggle from 0, 2 random, 3 ready=1 with load held high mid-frame.
  task automatic run_frame(input int d, b, s, input bit inv, input logic [39:0] nibs, input int len,
                           input bit st, input int mode, input string nm);
    int n, cyc, busy_cnt;
    bit done, stall, rdy;
    logic [3:0] pd;
    logic pl;
    det = d[13:0];
    c_packed = {s[13:0], b[13:0]};
    invalid = inv;
    load = 1;
    @(negedge clk);
    load = (mode == 3);
    det = 14'h1555;
    c_packed = {14'h2aaa, 14'h0123};
    invalid = 0;
    if (!inv) chk({nm, " sat"}, 32'(sat), 32'(st));
    n = 0; cyc = 0; busy_cnt = 0; done = 0; stall = 0; pd = 0; pl = 0;
    while (!done && cyc < 200) begin
      busy_cnt += busy;
      rdy = (mode == 1) ? cyc[0] : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      tx_ready = rdy;
      if (stall) begin
        chk({nm, " stall valid"}, 32'(tx_valid), 1);
        chk({nm, " stall data"}, 32'({tx_last, tx_data}), 32'({pl, pd}));
      end
      if (tx_valid && rdy) begin
        chk({nm, " nibble"}, 32'(tx_data), 32'(nibs[39 - 4*n -: 4]));
        chk({nm, " last"}, 32'(tx_last), 32'(n == len - 1));
        if (tx_last) done = 1;
        n++;
      end
      stall = tx_valid && !rdy;
      pd = tx_data;
      pl = tx_last;
      @(negedge clk);
      cyc++;
    end
    load = 0;
    chk({nm, " length"}, 32'(n), 32'(len));
    chk({nm, " idle after"}, 32'({tx_valid, busy, tx_data, tx_last}), 0);
    if (mode == 1) chk({nm, " busy cycles"}, 32'(busy_cnt), 32'(2 * len));
    if (!inv) chk({nm, " sat held"}, 32'(sat), 32'(st));
    @(negedge clk);
    chk({nm, " no restart"}, 32'(tx_valid), 0);
  endtask
  initial begin
    logic [39:0] en;
    int el, d, b, s;
    bit es, inv;
    vt[0] = '{6, 1, 1, 0, 40'hA006001001, 10, 0, 0};
    vt[1] = '{-3, 150, -8192, 0, 40'hAF03099F99, 10, 1, 0};
    vt[2] = '{0, 0, 0, 1, 40'hE000000000, 1, 0, 0};
    vt[3] = '{6, 1, 1, 0, 40'hA006001001, 10, 0, 1};
    vt[4] = '{6, 1, 1, 0, 40'hA006001001, 10, 0, 3};
    vt[5] = '{99, -99, 100, 0, 40'hA099F99099, 10, 1, 0};
    vt[6] = '{0, -100, -1, 0, 40'hA000F99F01, 10, 1, 1};
    vt[7] = '{10, -10, 9, 0, 40'hA010F10009, 10, 0, 2};
    repeat (2) @(negedge clk);
    chk("reset outputs", 32'({tx_valid, busy, tx_data, tx_last, sat}), 0);
    rst = 0;
    for (int i = 0; i < 8; i++)
      run_frame(vt[i].d, vt[i].b, vt[i].s, vt[i].inv, vt[i].nibs, vt[i].len, vt[i].sat, vt[i].mode, $sformatf("vec%0d", i));
    det = 14'h3ffd;
    c_packed = {14'h2000, 14'd150};
    invalid = 0;
    tx_ready = 1;
    load = 1;
    @(negedge clk);
    load = 0;
    repeat (4) @(negedge clk);
    chk("abort mid nibble", 32'(tx_data), 32'h0);
    #2 rst = 1;
    #1 chk("abort outputs", 32'({tx_valid, busy, tx_data, tx_last, sat}), 0);
    @(negedge clk);
    rst = 0;
    run_frame(6, 1, 1, 0, 40'hA006001001, 10, 0, 0, "after abort");
    for (int k = 0; k < 40; k++) begin
      d = $urandom_range(0, 1) ? int'($urandom_range(0, 198)) - 99 : int'($urandom_range(0, 16383));
      b = $urandom_range(0, 1) ? int'($urandom_range(0, 198)) - 99 : int'($urandom_range(0, 16383));
      s = $urandom_range(0, 1) ? int'($urandom_range(0, 198)) - 99 : int'($urandom_range(0, 16383));
      if (d > 8191) d -= 16384;
      if (b > 8191) b -= 16384;
      if (s > 8191) s -= 16384;
      inv = ($urandom_range(0, 7) == 0);
      model(d, b, s, inv, en, el, es);
      run_frame(d, b, s, inv, en, el, es, 2, $sformatf("rand%0d", k));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regression_result_tx.md
REGRESSION_RESULT_TX -- requirements
Module: regression_result_tx

Interface
REQ-001 SHALL have parameter ELEM_WIDTH, default 14, the width of each signed result element.
REQ-002 SHALL have port clk, input, 1 bit, the rising-edge clock.
REQ-003 SHALL have port rst, input, 1 bit, the asynchronous active-high reset.
REQ-004 SHALL have port load, input, 1 bit, a request to capture results and start a frame.
REQ-005 SHALL have port c_packed, input, 2*ELEM_WIDTH bits: low element is intercept b, high element is slope; both signed.
REQ-006 SHALL have port det, input, ELEM_WIDTH bits, the signed determinant.
REQ-007 SHALL have port invalid, input, 1 bit, set when the determinant is zero.
REQ-008 SHALL have port tx_data, output, 4 bits, the current nibble.
REQ-009 SHALL have port tx_valid, output, 1 bit, meaning tx_data is valid.
REQ-010 SHALL have port tx_ready, input, 1 bit, the sink's acceptance signal.
REQ-011 SHALL have port tx_last, output, 1 bit, marking the final nibble of a frame.
REQ-012 SHALL have port busy, output, 1 bit, high while a frame is in progress.
REQ-013 SHALL have port sat, output, 1 bit, a per-frame sticky saturation flag.

Function
REQ-014 SHALL implement a two-state FSM, IDLE and SEND, with a nibble index counter 0..9.
REQ-015 SHALL, in IDLE with load=1 at a clock edge, do all of the following at that edge:
- capture det, b, slope and invalid into internal registers;
- clear sat, then set it per REQ-019;
- enter SEND with index 0.
REQ-016 SHALL ignore load while busy=1, including the cycle of the final transfer; the captured values SHALL NOT change mid-frame.
REQ-017 SHALL drive busy=1 and tx_valid=1 exactly when in SEND; the first nibble is valid in the cycle after the capturing edge (1-cycle latency).
REQ-018 SHALL send a valid frame as 10 nibbles, in this order:
- header 0xA;
- det: sign, tens, ones;
- b: sign, tens, ones;
- slope: sign, tens, ones.
REQ-019 SHALL encode each value as follows:
- sign nibble is 0x0 if value >= 0 and 0xF if negative;
- tens and ones are the decimal digits of the absolute value;
- an absolute value > 99 (including the most negative code) SHALL saturate to tens=9, ones=9 and set sat.
REQ-020 SHALL, if invalid was captured as 1, send a 1-nibble frame of 0xE with tx_last=1.
REQ-021 SHALL complete a transfer only on a rising edge where tx_valid=1 and tx_ready=1; on each transfer the index advances.
REQ-022 SHALL hold tx_data and tx_last stable while tx_valid=1 and tx_ready=0; tx_valid SHALL NOT drop without a transfer.
REQ-023 SHALL assert tx_last only on the final nibble (index 9, or the 0xE header).
REQ-024 SHALL return to IDLE on the transfer of the tx_last nibble; tx_valid=0 in the next cycle.
REQ-025 SHALL compute digits from the captured registers only, never from live inputs.
REQ-026 SHALL drive tx_data=0 and tx_last=0 while in IDLE.
REQ-027 SHALL keep sat valid from the cycle after load until the next accepted load.

Reset
REQ-028 SHALL, while rst=1 asynchronously, force the following regardless of clk, and abort any frame in progress:
- state IDLE, index 0;
- tx_valid=0, tx_last=0, tx_data=0, busy=0, sat=0;
- all captured registers cleared.
REQ-029 SHALL accept load on the first clock edge after rst deasserts.

Verification
REQ-030 SHALL pass this nominal case: det=6, b=1, slope=1, invalid=0, load pulse, tx_ready=1 -> nibbles A,0,0,6,0,0,1,0,0,1 on 10 consecutive cycles, tx_last only on the 10th, sat=0.
REQ-031 SHALL pass this negative/saturation case: det=-3, b=150, slope=-8192 -> A,F,0,3,0,9,9,F,9,9 with sat=1.
REQ-032 SHALL pass this invalid case: invalid=1, det=0 -> a single nibble E with tx_last=1, then busy=0.
REQ-033 SHALL pass this backpressure case: tx_ready toggles 0/1 every cycle during the frame of REQ-030 -> identical nibble sequence, data stable during stalls, 20 cycles of busy.
REQ-034 SHALL pass this busy-load case: load pulses again mid-frame with different inputs -> the first frame is unchanged and no second frame starts; a load after busy falls starts a new frame.
REQ-035 SHALL pass this reset-abort case: rst pulses after the 4th transfer -> all outputs 0 immediately; a subsequent load restarts from header 0xA.
